rv_mem_arbiter: RTL and testbench
=================================

// Module: rv_mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF fetch port and the MEM-stage load/store port.
//  Sequences one outstanding transaction at a time through a req/ready/rvalid memory handshake.
//  Returns per-requester grant/response pulses; the pipeline uses ~rvalid as its stall source.
//  Adds a response timeout so a silent memory cannot hang the core.
// PARAMETERS
//  AW            32   address width
//  DW            32   data width; byte enables are DW/8 bits
//  TIMEOUT_CYC   255  max cycles in WAIT before abort; 0 disables the timeout
//  MAX_DSTREAK   4    consecutive data grants before fetch is forced (RV_ARB_FAIR_EN only)
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  rst        in   1     synchronous reset, active-high
//  i_req      in   1     fetch request (read-only)
//  i_addr     in   AW    fetch address
//  i_gnt      out  1     1-cycle pulse: fetch request captured
//  i_rvalid   out  1     1-cycle pulse: i_rdata valid
//  i_rdata    out  DW    fetched word
//  i_err      out  1     qualifies i_rvalid: timeout abort
//  d_req      in   1     load/store request
//  d_we       in   1     1=store, 0=load
//  d_be       in   DW/8  byte enables
//  d_addr     in   AW    data address
//  d_wdata    in   DW    store data
//  d_gnt      out  1     1-cycle pulse: data request captured
//  d_rvalid   out  1     1-cycle pulse: load data valid / store acknowledged
//  d_rdata    out  DW    load data
//  d_err      out  1     qualifies d_rvalid: timeout abort
//  m_req      out  1     memory request, held until m_ready
//  m_we       out  1     memory write
//  m_be       out  DW/8  memory byte enables
//  m_addr     out  AW    memory address
//  m_wdata    out  DW    memory write data
//  m_ready    in   1     memory accepted request this cycle
//  m_rvalid   in   1     memory response, for both reads and writes
//  m_rdata    in   DW    memory read data
// BEHAVIOUR
//  - Reset: state=IDLE; owner=NONE; streak=0; timer=0. All outputs are 0 and the m_* fields are 0.
//  - FSM states: IDLE, ISSUE, WAIT.
//  - IDLE
//    - If any req is present, select a requester and pulse its x_gnt combinationally in the same cycle.
//    - Latch addr/we/be/wdata; go to ISSUE.
//    - Priority: d_req over i_req; the older instruction wins.
//  - ISSUE
//    - Drive m_req=1 with the latched fields, held stable.
//    - On m_ready go to WAIT with timer=0.
//  - WAIT
//    - m_req=0.
//    - On m_rvalid: pulse owner's x_rvalid; x_rdata=m_rdata (combinational passthrough); go to IDLE.
//    - If TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1 without m_rvalid: pulse x_rvalid with x_err=1, rdata=0; go to IDLE.
//  - Minimum latency: gnt at cycle t, m_req at t+1, rvalid at t+2.
//  - One IDLE bubble separates transactions; peak throughput is 1 access per 3 cycles.
//  - m_rvalid outside WAIT is ignored.
//  - m_rvalid and the timeout expiring in the same cycle: the response wins and err=0.
//  - Requests arriving while busy wait. Requesters hold req/fields until gnt, then may change them.
//  - i_gnt and d_gnt are never both 1. At most one x_rvalid fires per cycle.
//  - A store's d_rvalid carries d_rdata=0.
//  - Reset mid-transaction: return to IDLE, drop the outstanding response, emit no rvalid.
//  - Timer: saturating counter of width $clog2(TIMEOUT_CYC+1); it does not run outside WAIT.
// CONFIGURATION
//  RV_ARB_FAIR_EN defined
//    - Streak counter increments on d_gnt and clears on i_gnt.
//    - When streak==MAX_DSTREAK and i_req=1, fetch wins in IDLE.
//  RV_ARB_FAIR_EN undefined
//    - Strict data priority; the streak counter is absent.
// STRUCTURE
//  - Package rv_arb_pkg:
//    - arb_state_e {IDLE,ISSUE,WAIT}
//    - arb_owner_e {NONE,IFETCH,DATA}
//    - request struct {we,be,addr,wdata}
//  - Sub-module rv_arb_timeout_ctr: enable/clear/expire, parameter TIMEOUT_CYC.
// TESTING
//  1. i_req=1, i_addr=0x100, m_ready=1 at t+1, m_rvalid=1 at t+2 with rdata=0x00500093
//     -> i_gnt at t; i_rvalid at t+2 with i_rdata=0x00500093.
//  2. i_req and d_req together, d_we=1, d_addr=0x2000, be=0xF, wdata=0xDEADBEEF
//     -> d_gnt first; m_we=1 with those fields; fetch granted in the IDLE cycle after d_rvalid.
//  3. m_ready withheld 3 cycles in ISSUE
//     -> m_req and fields stable for 4 cycles; no gnt or rvalid pulses meanwhile.
//  4. TIMEOUT_CYC=8, m_rvalid never asserted
//     -> x_rvalid with x_err=1 on the 8th WAIT cycle; next request served normally.
//  5. rst=1 while in WAIT, then m_rvalid=1 next cycle
//     -> no x_rvalid; outputs 0; state IDLE.
//  6. RV_ARB_FAIR_EN, MAX_DSTREAK=4, d_req and i_req held continuously
//     -> grant order D,D,D,D,I,D,D,D,D,I.

Source files
------------

// File: rtl/rv_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM states, owner tags
// and the latched request record.
package rv_arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  localparam int ARB_BW = ARB_DW / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
  typedef enum logic [1:0] {NONE, IFETCH, DATA} arb_owner_e;

  // Field widths follow ARB_AW/ARB_DW; overriding the arbiter widths means editing these too.
  typedef struct packed {
    logic              we;
    logic [ARB_BW-1:0] be;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/rv_arb_timeout_ctr.sv
// Saturating WAIT-state response timer; expire flags the last allowed cycle.
// TIMEOUT_CYC=0 removes the counter and never expires.
module rv_arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      logic [TW-1:0] timer_reg;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          timer_reg <= '0;
        end else if (en && (timer_reg != {TW{1'b1}})) begin
          timer_reg <= timer_reg + 1'b1;
        end
      end

      assign expire = en && (timer_reg == TW'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Define RV_ARB_FAIR_EN to force a fetch grant after MAX_DSTREAK back-to-back data grants.
module rv_mem_arbiter
  import rv_arb_pkg::*;
#(
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int TIMEOUT_CYC = 255
`ifdef RV_ARB_FAIR_EN
  , parameter int MAX_DSTREAK = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  arb_state_e state_reg, state_next;
  arb_owner_e owner_reg, owner_next;
  arb_req_t   req_reg, req_next;
  logic       tmo_expire;
  logic       fetch_wins;
  logic [DW-1:0] resp_data;

  rv_arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .en     (state_reg == WAIT),
    .clr    (state_reg != WAIT),
    .expire (tmo_expire)
  );

`ifdef RV_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  logic [SW-1:0] streak_reg;

  always_ff @(posedge clk) begin
    if (rst || i_gnt) begin
      streak_reg <= '0;
    end else if (d_gnt && (streak_reg != SW'(MAX_DSTREAK))) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

  assign fetch_wins = i_req && (!d_req || (streak_reg == SW'(MAX_DSTREAK)));
`else
  assign fetch_wins = i_req && !d_req;
`endif

  // A real response beats a same-cycle timeout; an abort returns zero data.
  assign resp_data = m_rvalid ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= NONE;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      req_reg   <= req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    req_next   = req_reg;
    i_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_err      = 1'b0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    d_err      = 1'b0;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_be       = '0;
    m_addr     = '0;
    m_wdata    = '0;
    // Outputs stay silent during reset so an in-flight response is dropped.
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (fetch_wins) begin
            i_gnt         = 1'b1;
            owner_next    = IFETCH;
            req_next.we   = 1'b0;
            req_next.be   = '1;
            req_next.addr = i_addr;
            req_next.wdata = '0;
            state_next    = ISSUE;
          end else if (d_req) begin
            d_gnt          = 1'b1;
            owner_next     = DATA;
            req_next.we    = d_we;
            req_next.be    = d_be;
            req_next.addr  = d_addr;
            req_next.wdata = d_wdata;
            state_next     = ISSUE;
          end
        end
        ISSUE: begin
          m_req   = 1'b1;
          m_we    = req_reg.we;
          m_be    = req_reg.be;
          m_addr  = req_reg.addr;
          m_wdata = req_reg.wdata;
          if (m_ready) state_next = WAIT;
        end
        WAIT: begin
          if (m_rvalid || tmo_expire) begin
            if (owner_reg == IFETCH) begin
              i_rvalid = 1'b1;
              i_err    = !m_rvalid;
              i_rdata  = resp_data;
            end else begin
              d_rvalid = 1'b1;
              d_err    = !m_rvalid;
              d_rdata  = req_reg.we ? '0 : resp_data;
            end
            owner_next = NONE;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed self-checking bench for rv_mem_arbiter (TIMEOUT_CYC=8); honours RV_ARB_FAIR_EN.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be, m_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          checks = 0;
  int          failures = 0;
  logic        exp_d;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0;
    d_wdata = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    next_cycle();
    next_cycle();
    i_req = 1'b1; m_rvalid = 1'b1;
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    $display("reset: outputs quiet");

    // 1: single fetch, minimum latency
    next_cycle();
    rst = 0; m_rvalid = 0; i_addr = 32'h100;
    #1;
    chk("t1_i_gnt", i_gnt, 1);
    chk("t1_d_gnt", d_gnt, 0);
    chk("t1_m_req_idle", m_req, 0);
    next_cycle();
    i_req = 0; i_addr = 32'h0; m_ready = 1;
    #1;
    chk("t1_m_req", m_req, 1);
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_we", m_we, 0);
    next_cycle();
    m_ready = 0; m_rvalid = 1; m_rdata = 32'h00500093;
    #1;
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 32'h00500093);
    chk("t1_i_err", i_err, 0);
    chk("t1_m_req_wait", m_req, 0);
    next_cycle();
    m_rvalid = 0;
    #1;
    chk("t1_i_rvalid_done", i_rvalid, 0);
    $display("t1: fetch 0x100 -> rdata 0x00500093");

    // 2: data beats fetch; fetch served in the following IDLE cycle
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_be = 4'hF; d_wdata = 32'hDEADBEEF;
    #1;
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_i_gnt", i_gnt, 0);
    next_cycle();
    d_req = 0; d_wdata = 32'h0; d_addr = 32'h0; m_ready = 1;
    #1;
    chk("t2_m_we", m_we, 1);
    chk("t2_m_addr", m_addr, 32'h2000);
    chk("t2_m_be", m_be, 4'hF);
    chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("t2_i_gnt_busy", i_gnt, 0);
    next_cycle();
    m_ready = 0; m_rvalid = 1; m_rdata = 32'h12345678;
    #1;
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata_store", d_rdata, 0);
    chk("t2_i_rvalid", i_rvalid, 0);
    chk("t2_m_addr_wait", m_addr, 0);
    next_cycle();
    m_rvalid = 0;
    #1;
    chk("t2_i_gnt_after", i_gnt, 1);
    $display("t2: store 0x2000 then fetch 0x104 granted");

    // 3: m_ready withheld 3 cycles; stray m_rvalid in ISSUE ignored
    next_cycle();
    i_req = 0; m_rvalid = 1; m_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) m_rvalid = 0;
      if (k == 3) m_ready = 1;
      #1;
      chk("t3_m_req", m_req, 1);
      chk("t3_m_addr", m_addr, 32'h104);
      chk("t3_gnt", {i_gnt, d_gnt}, 0);
      chk("t3_rvalid", {i_rvalid, d_rvalid}, 0);
      next_cycle();
    end
    $display("t3: ISSUE held 4 cycles");

    // 4: timeout on the 8th WAIT cycle
    m_ready = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t4_i_rvalid", i_rvalid, (k == 7) ? 1 : 0);
      chk("t4_i_err", i_err, (k == 7) ? 1 : 0);
      chk("t4_i_rdata", i_rdata, 0);
      next_cycle();
    end
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'h3;
    #1;
    chk("t4_d_gnt", d_gnt, 1);
    next_cycle();
    d_req = 0; m_ready = 1;
    #1;
    chk("t4_m_addr", m_addr, 32'h3000);
    chk("t4_m_be", m_be, 4'h3);
    chk("t4_m_we", m_we, 0);
    next_cycle();
    m_ready = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D;
    #1;
    chk("t4_d_rvalid", d_rvalid, 1);
    chk("t4_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("t4_d_err", d_err, 0);
    next_cycle();
    m_rvalid = 0;
    $display("t4: timeout abort, then load 0x3000 served");

    // response arriving on the last timeout cycle wins
    i_req = 1; i_addr = 32'h200;
    #1;
    chk("tw_i_gnt", i_gnt, 1);
    next_cycle();
    i_req = 0; m_ready = 1;
    next_cycle();
    m_ready = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("tw_i_rvalid_early", i_rvalid, 0);
      next_cycle();
    end
    m_rvalid = 1; m_rdata = 32'h00000013;
    #1;
    chk("tw_i_rvalid", i_rvalid, 1);
    chk("tw_i_err", i_err, 0);
    chk("tw_i_rdata", i_rdata, 32'h13);
    next_cycle();
    m_rvalid = 0;
    $display("tw: response on expiry cycle, err=0");

    // 5: reset while in WAIT drops the response
    i_req = 1; i_addr = 32'h300;
    next_cycle();
    i_req = 0; m_ready = 1;
    next_cycle();
    m_ready = 0; rst = 1;
    #1;
    chk("t5_rst_rvalid", i_rvalid, 0);
    chk("t5_rst_m_req", m_req, 0);
    next_cycle();
    rst = 0; m_rvalid = 1; m_rdata = 32'h55;
    #1;
    chk("t5_i_rvalid", i_rvalid, 0);
    chk("t5_d_rvalid", d_rvalid, 0);
    chk("t5_m_req", m_req, 0);
    next_cycle();
    m_rvalid = 0;
    $display("t5: reset in WAIT, response dropped");

    // 6: both requesters held continuously
    d_req = 1; d_we = 0; d_addr = 32'h4000; i_req = 1; i_addr = 32'h400;
    for (int k = 0; k < 10; k++) begin
`ifdef RV_ARB_FAIR_EN
      exp_d = ((k % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      #1;
      chk("t6_d_gnt", d_gnt, exp_d);
      chk("t6_i_gnt", i_gnt, !exp_d);
      $display("t6: grant %0d -> %s", k, d_gnt ? "D" : (i_gnt ? "I" : "-"));
      next_cycle();
      m_ready = 1;
      next_cycle();
      m_ready = 0; m_rvalid = 1;
      next_cycle();
      m_rvalid = 0;
    end
    d_req = 0; i_req = 0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
